// File: rtl/buscaminas_pkg.sv
// Shared definitions for the minesweeper board reader: board size, display codes, FSM states.
package buscaminas_pkg;

    localparam int BOARD_DIM = 8;

    localparam logic [3:0] CODE_BOMBA   = 4'h9;
    localparam logic [3:0] CODE_BANDERA = 4'hA;
    localparam logic [3:0] CODE_CURSOR  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_EMIT,
        ST_DONE
    } estado_t;

endpackage

// File: rtl/lector_tablero_contador_vecinos.sv
// Combinational popcount of the up-to-8 bomb bits surrounding (fila, col);
// neighbours outside the board and the cell itself never contribute.
module contador_vecinos
    import buscaminas_pkg::*;
(
    input  logic [BOARD_DIM-1:0][BOARD_DIM-1:0] i_tablero,
    input  logic [2:0]                          i_fila,
    input  logic [2:0]                          i_col,
    output logic [3:0]                          o_cuenta
);

    int w_fr;
    int w_fc;

    always_comb begin
        o_cuenta = '0;
        w_fr     = 0;
        w_fc     = 0;
        for (int unsigned dr = 0; dr < 3; dr++) begin
            for (int unsigned dc = 0; dc < 3; dc++) begin
                w_fr = int'(i_fila) + int'(dr) - 1;
                w_fc = int'(i_col) + int'(dc) - 1;
                if (!(dr == 1 && dc == 1) &&
                    w_fr >= 0 && w_fr < BOARD_DIM &&
                    w_fc >= 0 && w_fc < BOARD_DIM) begin
                    o_cuenta = o_cuenta + 4'(i_tablero[w_fr[2:0]][w_fc[2:0]]);
                end
            end
        end
    end

endmodule

// File: rtl/lector_tablero.sv
// Snapshots the bomb/flag matrices and streams one display code per cell in row-major order.
// Optional macro LECTOR_CURSOR_EN: the live cursor cell reports CODE_CURSOR.
module lector_tablero
    import buscaminas_pkg::*;
#(
    parameter int DIM = BOARD_DIM
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0][7:0] bombas,
    input  logic [7:0][7:0] banderas,
    input  logic [2:0]      cursor_fila,
    input  logic [2:0]      cursor_col,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_fila,
    output logic [2:0]      out_col,
    output logic [3:0]      out_code,
    output logic            busy,
    output logic            done,
    output logic [6:0]      total_bombas
);

    localparam logic [5:0] LAST_IDX = 6'(DIM * DIM - 1);

    estado_t         r_estado;
    estado_t         w_siguiente;
    logic [7:0][7:0] r_snap_bombas;
    logic [7:0][7:0] r_snap_banderas;
    logic [5:0]      r_idx;
    logic [6:0]      r_acc;
    logic [6:0]      r_total;
    logic [2:0]      r_fila;
    logic [2:0]      r_col;
    logic [3:0]      r_code;

    logic [2:0]      w_fila;
    logic [2:0]      w_col;
    logic [3:0]      w_cuenta;
    logic [3:0]      w_code;
    logic            w_bomba;
    logic            w_bandera;
    logic            w_ultimo;

    assign w_fila    = r_idx[5:3];
    assign w_col     = r_idx[2:0];
    assign w_bomba   = r_snap_bombas[w_fila][w_col];
    assign w_bandera = r_snap_banderas[w_fila][w_col];
    assign w_ultimo  = (r_idx == LAST_IDX);

    contador_vecinos u_contador (
        .i_tablero (r_snap_bombas),
        .i_fila    (w_fila),
        .i_col     (w_col),
        .o_cuenta  (w_cuenta)
    );

    // Priority: cursor (optional) > flag > bomb > neighbour count.
    always_comb begin
        w_code = w_cuenta;
        if (w_bomba)
            w_code = CODE_BOMBA;
        if (w_bandera)
            w_code = CODE_BANDERA;
`ifdef LECTOR_CURSOR_EN
        if (cursor_fila == w_fila && cursor_col == w_col)
            w_code = CODE_CURSOR;
`endif
    end

`ifndef LECTOR_CURSOR_EN
    logic w_unused_cursor;
    assign w_unused_cursor = ^{cursor_fila, cursor_col};
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_estado <= ST_IDLE;
        else
            r_estado <= w_siguiente;
    end

    always_comb begin
        w_siguiente = r_estado;
        case (r_estado)
            ST_IDLE: if (start) w_siguiente = ST_LOAD;
            ST_LOAD: w_siguiente = ST_CALC;
            ST_CALC: w_siguiente = ST_EMIT;
            ST_EMIT: if (out_ready) w_siguiente = w_ultimo ? ST_DONE : ST_CALC;
            ST_DONE: w_siguiente = ST_IDLE;
            default: w_siguiente = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_estado == ST_EMIT);
        busy      = (r_estado != ST_IDLE);
        done      = (r_estado == ST_DONE);
    end

    // total is committed on the final transfer so it is already visible while done is high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_bombas   <= '0;
            r_snap_banderas <= '0;
            r_idx           <= '0;
            r_acc           <= '0;
            r_total         <= '0;
            r_fila          <= '0;
            r_col           <= '0;
            r_code          <= '0;
        end else begin
            case (r_estado)
                ST_LOAD: begin
                    r_snap_bombas   <= bombas;
                    r_snap_banderas <= banderas;
                    r_idx           <= '0;
                    r_acc           <= '0;
                    r_total         <= '0;
                end
                ST_CALC: begin
                    r_code <= w_code;
                    r_fila <= w_fila;
                    r_col  <= w_col;
                    r_acc  <= r_acc + 7'(w_bomba);
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (w_ultimo)
                            r_total <= r_acc;
                        else
                            r_idx <= r_idx + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_fila     = r_fila;
    assign out_col      = r_col;
    assign out_code     = r_code;
    assign total_bombas = r_total;

endmodule

// File: tb/tb_lector_tablero.sv
// Self-checking bench for lector_tablero: table-driven scans against a behavioural board model.
module tb_lector_tablero;
    import buscaminas_pkg::*;

    typedef logic [7:0][7:0] tablero_t;

    typedef struct {
        tablero_t b;
        tablero_t f;
        int       mode;
        int       exp_total;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    tablero_t    bombas;
    tablero_t    banderas;
    logic [2:0]  cursor_fila;
    logic [2:0]  cursor_col;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_fila;
    logic [2:0]  out_col;
    logic [3:0]  out_code;
    logic        busy;
    logic        done;
    logic [6:0]  total_bombas;

    tablero_t    cv_tab;
    logic [2:0]  cv_f;
    logic [2:0]  cv_c;
    logic [3:0]  cv_n;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] got   [64];
    logic [3:0] saved [64];
    vec_t tbl [6];

    always #5 clk = ~clk;

    lector_tablero #(.DIM(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bombas       (bombas),
        .banderas     (banderas),
        .cursor_fila  (cursor_fila),
        .cursor_col   (cursor_col),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_fila     (out_fila),
        .out_col      (out_col),
        .out_code     (out_code),
        .busy         (busy),
        .done         (done),
        .total_bombas (total_bombas)
    );

    contador_vecinos u_cv (
        .i_tablero (cv_tab),
        .i_fila    (cv_f),
        .i_col     (cv_c),
        .o_cuenta  (cv_n)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ref_count(input tablero_t b, input int r, input int c);
        int n = 0;
        for (int rr = r - 1; rr <= r + 1; rr++)
            for (int cc = c - 1; cc <= c + 1; cc++)
                if ((rr != r || cc != c) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                    n += int'(b[rr][cc]);
        return n;
    endfunction

    function automatic int ref_code(input tablero_t b, input tablero_t f, input int r, input int c);
`ifdef LECTOR_CURSOR_EN
        if (r == int'(cursor_fila) && c == int'(cursor_col)) return 15;
`endif
        if (f[r][c]) return 10;
        if (b[r][c]) return 9;
        return ref_count(b, r, c);
    endfunction

    // mode 0: ready always 1; mode 1: ready 1 of every 3 cycles; mode 2: random ready
    task automatic run_scan(input tablero_t b, input tablero_t f, input int mode,
                            input int exp_total, input int abort_k);
        int t, k, ndone;
        logic pv, fin, aborted;
        logic [2:0] pf, pc;
        logic [3:0] pcode;
        bombas = b;
        banderas = f;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        t = 0; k = 0; ndone = 0; pv = 1'b0; fin = 1'b0; aborted = 1'b0;
        pf = '0; pc = '0; pcode = '0;
        while (!fin && t < 2000) begin
            if (t == 1) begin
                bombas   = ~b;
                banderas = {$urandom, $urandom};
            end
            if (done) ndone++;
            if (pv) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_fila", int'(out_fila), int'(pf));
                chk("hold_col", int'(out_col), int'(pc));
                chk("hold_code", int'(out_code), int'(pcode));
            end else if (out_valid && k < 64) begin
                if (k == 0) chk("first_latency", t, 2);
                chk("rec_fila", int'(out_fila), k / 8);
                chk("rec_col", int'(out_col), k % 8);
                chk("rec_code", int'(out_code), ref_code(b, f, k / 8, k % 8));
                got[k] = out_code;
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (t % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = (mode == 1 && t == 40) || (mode == 2 && out_valid && out_ready && k == 63);
            if (abort_k >= 0 && out_valid && k == abort_k) begin
                rst = 1'b1;
                aborted = 1'b1;
                fin = 1'b1;
            end
            pv = out_valid && !out_ready;
            pf = out_fila; pc = out_col; pcode = out_code;
            if (!aborted && out_valid && out_ready) begin
                k++;
                if (k == 64) fin = 1'b1;
            end
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        if (aborted) begin
            chk("rst_valid", int'(out_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_code", int'(out_code), 0);
            rst = 1'b0;
            out_ready = 1'b1;
            ndone = 0;
            repeat (5) begin
                @(negedge clk);
                if (done || busy) ndone++;
            end
            chk("rst_quiet", ndone, 0);
        end else if (!fin) begin
            chk("scan_timeout", k, 64);
        end else begin
            chk("done_pulse", int'(done), 1);
            chk("done_busy", int'(busy), 1);
            chk("early_done", ndone, 0);
            chk("total_bombas", int'(total_bombas), exp_total);
            if (mode == 0) chk("done_latency", t, 129);
            @(negedge clk);
            chk("done_one_cycle", int'(done), 0);
            chk("idle_after_done", int'(busy), 0);
            chk("total_held", int'(total_bombas), exp_total);
        end
    endtask

    initial begin
        tablero_t ring, ringf, single, cb, cf;
        int mism;

        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        bombas = '0; banderas = '0; cursor_fila = '0; cursor_col = '0;
        cv_tab = '0; cv_f = '0; cv_c = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_code", int'(out_code), 0);
        chk("reset_pos", int'({out_fila, out_col}), 0);
        chk("reset_total", int'(total_bombas), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_stays", int'(busy), 0);

        // Standalone neighbour counter, including full and edge-heavy boards
        for (int unsigned n = 0; n < 4; n++) begin
            if (n == 0) cv_tab = '1;
            else cv_tab = {$urandom, $urandom};
            for (int unsigned i = 0; i < 64; i++) begin
                cv_f = 3'(i / 8);
                cv_c = 3'(i % 8);
                #1;
                chk("cv_count", int'(cv_n), ref_count(cv_tab, int'(i / 8), int'(i % 8)));
            end
        end

        single = '0; single[0][0] = 1'b1;
        ring = '0;
        ring[2][2] = 1'b1; ring[2][3] = 1'b1; ring[2][4] = 1'b1;
        ring[3][2] = 1'b1; ring[3][4] = 1'b1;
        ring[4][2] = 1'b1; ring[4][3] = 1'b1; ring[4][4] = 1'b1;
        ringf = '0; ringf[3][2] = 1'b1;

        tbl[0] = '{b: '0,     f: '0,    mode: 0, exp_total: 0};
        tbl[1] = '{b: single, f: '0,    mode: 0, exp_total: 1};
        tbl[2] = '{b: ring,   f: ringf, mode: 0, exp_total: 8};
        tbl[3] = '{b: ring,   f: ringf, mode: 1, exp_total: 8};
        tbl[4].b = {$urandom, $urandom};
        tbl[4].f = {$urandom, $urandom} & {$urandom, $urandom};
        tbl[4].mode = 2;
        tbl[4].exp_total = $countones(tbl[4].b);
        tbl[5].b = {$urandom, $urandom} | {$urandom, $urandom};
        tbl[5].f = '0;
        tbl[5].mode = 1;
        tbl[5].exp_total = $countones(tbl[5].b);

        for (int unsigned i = 0; i < 6; i++) begin
            run_scan(tbl[i].b, tbl[i].f, tbl[i].mode, tbl[i].exp_total, -1);
            if (i == 1) begin
                chk("single_00", int'(got[0]), 9);
                chk("single_01", int'(got[1]), 1);
                chk("single_10", int'(got[8]), 1);
                chk("single_11", int'(got[9]), 1);
                chk("single_12", int'(got[10]), 0);
            end
            if (i == 2) begin
                chk("ring_33", int'(got[27]), 8);
                chk("ring_flag_32", int'(got[26]), 10);
                chk("ring_bomb_34", int'(got[28]), 9);
                for (int unsigned j = 0; j < 64; j++) saved[j] = got[j];
            end
            if (i == 3) begin
                mism = 0;
                for (int unsigned j = 0; j < 64; j++) if (got[j] != saved[j]) mism++;
                chk("stall_seq_match", mism, 0);
            end
        end

        // Reset mid-scan at record 20, then a fresh scan must start from (0,0)
        run_scan(ring, ringf, 0, 8, 20);
        run_scan(single, '0, 0, 1, -1);

        cursor_fila = 3'd2;
        cursor_col  = 3'd5;
        cb = '0; cb[2][5] = 1'b1; cb[7][7] = 1'b1;
        cf = '0; cf[2][5] = 1'b1;
        run_scan(cb, cf, 0, 2, -1);
`ifdef LECTOR_CURSOR_EN
        chk("cursor_25", int'(got[21]), 15);
`else
        chk("cursor_25", int'(got[21]), 10);
`endif
        chk("cursor_77", int'(got[63]), 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lector_tablero.md
# lector_tablero

Board reader for the minesweeper game. It takes a snapshot of the 8x8 bomb and flag matrices that the game core writes. It then streams one 4-bit display code per cell, in row-major order, over a valid/ready handshake to the display/render side. Each code encodes the cell's adjacent-bomb count, or marks the cell as a bomb or a flag.

## Interface
Parameters:
- DIM, 8, board side length; only 8 is supported.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse that requests a full board scan; honoured only in IDLE.
- bombas  in  [7:0][7:0]  bomb matrix; bombas[fila][col] = 1 means a bomb.
- banderas  in  [7:0][7:0]  flag matrix; same indexing as bombas.
- cursor_fila  in  3  cursor row (used only with the macro).
- cursor_col  in  3  cursor column (used only with the macro).
- out_valid  out  1  cell record valid.
- out_ready  in  1  consumer accepts the record.
- out_fila  out  3  row of the current record.
- out_col  out  3  column of the current record.
- out_code  out  4  cell code (see Operation).
- busy  out  1  high from LOAD through DONE.
- done  out  1  one-cycle pulse after the last record is accepted.
- total_bombas  out  7  number of bombs in the snapshot (0..64); valid from DONE until the next start.

## Operation
- State machine: IDLE, LOAD, CALC, EMIT, DONE.
- IDLE → LOAD when start=1. LOAD copies bombas and banderas into internal snapshot registers and clears idx (6-bit), total_bombas and the internal accumulator.
- LOAD → CALC unconditionally.
- CALC: computes the code for cell idx (fila = idx[5:3], col = idx[2:0]) from the snapshot and registers it into out_code, out_fila and out_col. It also adds that cell's bomb bit to the accumulator. Then goes to EMIT.
- EMIT: out_valid=1. If out_ready=0, stay in EMIT with every output held stable. If out_ready=1 and idx=63, go to DONE. If out_ready=1 and idx<63, increment idx and go to CALC.
- DONE: done=1 for one cycle, total_bombas is loaded from the accumulator, then go to IDLE.
- Code priority, highest first: cursor 4'hF (macro only); flag 4'hA; bomb 4'h9; otherwise the neighbour count 0..8.
- Neighbour count = popcount of the up to 8 adjacent snapshot bomb bits. Out-of-range neighbours at the edges and corners count as 0. The cell's own bit is excluded. The result is 4 bits unsigned.
- A flag on a bomb cell reports 4'hA.
- start is ignored while busy=1.
- Input matrix changes after LOAD have no effect on the current scan.

## Timing
- Reset values: state=IDLE, out_valid=0, out_fila=0, out_col=0, out_code=0, busy=0, done=0, total_bombas=0, idx=0.
- rst during any state returns to IDLE on the next edge. No done pulse is generated and the partial scan is discarded.
- start sampled high at edge N gives LOAD at N+1, CALC at N+2, and the first out_valid after edge N+2.
- Each record takes at least 2 cycles (CALC + EMIT). A full scan with out_ready held at 1 takes 1 (LOAD) + 128 cycles, followed by done in the next cycle.
- Handshake: a transfer occurs on an edge where out_valid & out_ready. out_valid never drops without a transfer, except on rst.
- start and the final transfer in the same cycle: start is ignored (busy=1).

## Configuration
- LECTOR_CURSOR_EN defined: a cell whose row and column equal cursor_fila/cursor_col, as sampled in CALC, reports 4'hF. This overrides flag and bomb. The cursor is live, not snapshotted.
- LECTOR_CURSOR_EN undefined: the cursor ports are present but ignored, and 4'hF is never produced.

## Structure
- buscaminas_pkg holds:
  - BOARD_DIM = 8;
  - code constants CODE_BOMBA = 4'h9, CODE_BANDERA = 4'hA, CODE_CURSOR = 4'hF;
  - a state enum typedef.
- Sub-module contador_vecinos: combinational. It takes the 8x8 snapshot, fila and col, and returns the 4-bit neighbour count. Its edge masking is tested on its own.

## Test plan
- Empty board, out_ready=1, start pulse → 64 records, all out_code=0, in order (0,0)..(7,7); done pulses 130 cycles after start is sampled; total_bombas=0.
- Single bomb at (0,0) → (0,0)=9; (0,1), (1,0) and (1,1) each =1; all other cells 0; total_bombas=1.
- Bombs filling all 8 neighbours of (3,3), with (3,3) empty → (3,3)=8; flag on bomb (3,2) → 4'hA; total_bombas=8.
- out_ready toggles 1 of every 3 cycles → every record is emitted exactly once, outputs hold during stalls, and the code sequence matches the ready=1 run.
- rst asserted while idx=20 in EMIT → next cycle out_valid=0, busy=0, no done pulse; a new start rescans from (0,0).
- LECTOR_CURSOR_EN defined, cursor=(2,5) on a flag cell → record (2,5) has code 4'hF; without the macro the same record has code 4'hA.
